// File: rtl/vi_mem_pkg.sv
// vi_mem_pkg: shared types and default widths for the vi_core memory-port arbiter.
package vi_mem_pkg;
    localparam int VI_ADDR_W = 20;
    localparam int VI_LINE_W = 128;
    localparam int VI_WORD_W = 32;
    localparam int OFS_W     = 4;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR} state_t;
endpackage

// File: rtl/vi_mem_arb_pick.sv
// vi_mem_arb_pick: fixed dcache priority, overridden when the fetch side is starving.
module vi_mem_arb_pick (
    input  logic ic_req,
    input  logic dc_req,
    input  logic starve,
    output logic pick_ic,
    output logic pick_dc
);
    always_comb begin
        pick_ic = ic_req && (!dc_req || starve);
        pick_dc = dc_req && !pick_ic;
    end
endmodule

// File: rtl/vi_mem_arbiter.sv
// vi_mem_arbiter: shares the single memory port between icache refills and dcache
// refills/stores, one transaction outstanding, with starvation guard and reply timeout.
module vi_mem_arbiter
    import vi_mem_pkg::*;
#(
    parameter int ADDR_W     = VI_ADDR_W,
    parameter int LINE_W     = VI_LINE_W,
    parameter int WORD_W     = VI_WORD_W,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_gnt_o,
    output logic              ic_ready_o,
    output logic [LINE_W-1:0] ic_data_o,
    input  logic              dc_req_i,
    input  logic              dc_we_i,
    input  logic              dc_byte_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [WORD_W-1:0] dc_wdata_i,
    output logic              dc_gnt_o,
    output logic              dc_ready_o,
    output logic [LINE_W-1:0] dc_data_o,
    output logic              mem_read_o,
    output logic [ADDR_W-1:0] mem_read_addr_o,
    output logic              mem_write_enable_o,
    output logic              mem_write_byte_o,
    output logic [ADDR_W-1:0] mem_write_addr_o,
    output logic [WORD_W-1:0] mem_write_data_o,
    input  logic              mem_data_ready_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    output logic              err_o
);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] wait_cnt;
    logic          owner_ic;
    logic          pick_ic, pick_dc, hit, expired;
    logic          unused_bits;
    assign unused_bits = ^{ic_addr_i[OFS_W-1:0], mem_addr_i[OFS_W-1:0]};
    vi_mem_arb_pick u_pick (
        .ic_req  (ic_req_i),
        .dc_req  (dc_req_i),
        .starve  (ic_req_i && streak == SW'(STARVE_LIM)),
        .pick_ic (pick_ic),
        .pick_dc (pick_dc)
    );
    // Replies are matched on line address only; stale or foreign replies are dropped.
    assign hit     = mem_data_ready_i && mem_addr_i[ADDR_W-1:OFS_W] == mem_read_addr_o[ADDR_W-1:OFS_W];
    assign expired = wait_cnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= IDLE;
            streak             <= '0;
            wait_cnt           <= '0;
            owner_ic           <= 1'b0;
            ic_gnt_o           <= 1'b0;
            ic_ready_o         <= 1'b0;
            ic_data_o          <= '0;
            dc_gnt_o           <= 1'b0;
            dc_ready_o         <= 1'b0;
            dc_data_o          <= '0;
            mem_read_o         <= 1'b0;
            mem_read_addr_o    <= '0;
            mem_write_enable_o <= 1'b0;
            mem_write_byte_o   <= 1'b0;
            mem_write_addr_o   <= '0;
            mem_write_data_o   <= '0;
            err_o              <= 1'b0;
        end else begin
            ic_gnt_o           <= 1'b0;
            ic_ready_o         <= 1'b0;
            dc_gnt_o           <= 1'b0;
            dc_ready_o         <= 1'b0;
            mem_read_o         <= 1'b0;
            mem_write_enable_o <= 1'b0;
            err_o              <= 1'b0;
            if (!ic_req_i || (state == IDLE && pick_ic))
                streak <= '0;
            else if (state == IDLE && pick_dc && streak != SW'(STARVE_LIM))
                streak <= streak + 1'b1;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (pick_ic || (pick_dc && !dc_we_i)) begin
                        state           <= RD_WAIT;
                        owner_ic        <= pick_ic;
                        ic_gnt_o        <= pick_ic;
                        dc_gnt_o        <= pick_dc;
                        mem_read_o      <= 1'b1;
                        mem_read_addr_o <= {pick_ic ? ic_addr_i[ADDR_W-1:OFS_W] : dc_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                    end else if (pick_dc) begin
                        state              <= WR;
                        dc_gnt_o           <= 1'b1;
                        dc_ready_o         <= 1'b1;
                        mem_write_enable_o <= 1'b1;
                        mem_write_byte_o   <= dc_byte_i;
                        mem_write_addr_o   <= dc_addr_i;
                        mem_write_data_o   <= dc_wdata_i;
                    end
                end
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (hit || expired) begin
                        state <= IDLE;
                        err_o <= !hit;
                        if (owner_ic) begin
                            ic_ready_o <= 1'b1;
                            ic_data_o  <= hit ? mem_data_i : '0;
                        end else begin
                            dc_ready_o <= 1'b1;
                            dc_data_o  <= hit ? mem_data_i : '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vi_mem_arbiter.sv
// tb_vi_mem_arbiter: directed checks of vi_mem_arbiter grant order, fills, stores, timeout, reset.
module tb_vi_mem_arbiter;
    logic         clk = 1'b0, rst = 1'b1;
    logic         ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, dc_byte = 1'b0;
    logic [19:0]  ic_addr = '0, dc_addr = '0, mem_addr = '0;
    logic [31:0]  dc_wdata = '0;
    logic         mem_rdy = 1'b0;
    logic [127:0] mem_data = '0;
    logic         ic_gnt, ic_ready, dc_gnt, dc_ready, mem_read, mem_we, mem_byte, err;
    logic [127:0] ic_data, dc_data;
    logic [19:0]  mem_raddr, mem_waddr;
    logic [31:0]  mem_wdata;
    int           tests = 0, fails = 0;
    logic         gi, gd, seen;
    int           n;

    localparam logic [127:0] L1 = 128'h0000_1111_2222_3333_4444_5555_0040_0313;
    localparam logic [127:0] L2 = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0001;
    localparam logic [127:0] L3 = 128'h0BAD_CAFE_0000_0000_1111_2222_3333_4444;
    localparam logic [127:0] L4 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;

    vi_mem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_gnt_o(ic_gnt), .ic_ready_o(ic_ready), .ic_data_o(ic_data),
        .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_byte_i(dc_byte), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
        .dc_gnt_o(dc_gnt), .dc_ready_o(dc_ready), .dc_data_o(dc_data),
        .mem_read_o(mem_read), .mem_read_addr_o(mem_raddr), .mem_write_enable_o(mem_we),
        .mem_write_byte_o(mem_byte), .mem_write_addr_o(mem_waddr), .mem_write_data_o(mem_wdata),
        .mem_data_ready_i(mem_rdy), .mem_data_i(mem_data), .mem_addr_i(mem_addr), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output logic i_g, output logic d_g);
        i_g = 1'b0;
        d_g = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ic_gnt || dc_gnt) begin
                i_g = ic_gnt;
                d_g = dc_gnt;
                break;
            end
        end
        chk("grant_seen", 128'(i_g | d_g), 128'(1));
    endtask

    task automatic respond(input logic [19:0] a, input logic [127:0] d);
        @(negedge clk);
        mem_rdy  = 1'b1;
        mem_addr = a;
        mem_data = d;
        @(negedge clk);
        mem_rdy  = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ic_data", ic_data, 128'(0));
        chk("rst_dc_data", dc_data, 128'(0));
        chk("rst_strobes", 128'({ic_gnt, ic_ready, dc_gnt, dc_ready, mem_read, mem_we, mem_byte, err}), 128'(0));
        chk("rst_addrs", 128'({mem_raddr, mem_waddr, mem_wdata}), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        // single fetch
        ic_req = 1'b1; ic_addr = 20'h08004;
        @(negedge clk);
        chk("fetch_gnt", 128'({ic_gnt, dc_gnt, mem_read}), 128'(3'b101));
        chk("fetch_raddr", 128'(mem_raddr), 128'(20'h08000));
        ic_req = 1'b0;
        @(negedge clk);
        chk("fetch_strobe_drop", 128'(mem_read), 128'(0));
        mem_rdy = 1'b1; mem_addr = 20'h08000; mem_data = L1;
        @(negedge clk);
        mem_rdy = 1'b0;
        chk("fetch_ready", 128'({ic_ready, dc_ready}), 128'(2'b10));
        chk("fetch_data", ic_data, L1);
        @(negedge clk);
        chk("fetch_ready_pulse", 128'(ic_ready), 128'(0));
        // contention, plus a mismatched reply tag
        ic_req = 1'b1; ic_addr = 20'h08010;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 20'h12000;
        @(negedge clk);
        chk("cont_dc_first", 128'({ic_gnt, dc_gnt}), 128'(2'b01));
        chk("cont_dc_raddr", 128'(mem_raddr), 128'(20'h12000));
        dc_req = 1'b0;
        respond(20'h12000, L2);
        chk("cont_dc_ready", 128'({ic_ready, dc_ready}), 128'(2'b01));
        chk("cont_dc_data", dc_data, L2);
        @(negedge clk);
        chk("cont_ic_gnt", 128'({ic_gnt, dc_gnt}), 128'(2'b10));
        chk("cont_ic_raddr", 128'(mem_raddr), 128'(20'h08010));
        chk("ic_data_hold", ic_data, L1);
        ic_req = 1'b0;
        respond(20'h08020, L4);
        chk("tag_mismatch_ignored", 128'(ic_ready), 128'(0));
        respond(20'h08010, L3);
        chk("cont_ic_ready", 128'(ic_ready), 128'(1));
        chk("cont_ic_data", ic_data, L3);
        // starvation guard
        ic_req = 1'b1; ic_addr = 20'h08020;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 20'h12040;
        for (int s = 0; s < 4; s++) begin
            wait_gnt(gi, gd);
            chk("starve_dc_grant", 128'({gi, gd}), 128'(2'b01));
            respond(20'h12040, L2);
        end
        wait_gnt(gi, gd);
        chk("starve_ic_grant", 128'({gi, gd}), 128'(2'b10));
        chk("starve_streak_clear", 128'(dut.streak), 128'(0));
        ic_req = 1'b0;
        dc_req = 1'b0;
        respond(20'h08020, L4);
        chk("starve_ic_data", ic_data, L4);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= ic_gnt | dc_gnt;
        end
        chk("dropped_req_no_gnt", 128'(seen), 128'(0));
        // stray reply while idle
        respond(20'h12040, L3);
        chk("idle_reply_ignored", 128'({ic_ready, dc_ready}), 128'(0));
        // stores
        dc_req = 1'b1; dc_we = 1'b1; dc_byte = 1'b1; dc_addr = 20'h12003; dc_wdata = 32'h0000_00AB;
        @(negedge clk);
        chk("bstore_strobes", 128'({dc_gnt, dc_ready, mem_we, mem_byte, mem_read}), 128'(5'b11110));
        chk("bstore_addr", 128'(mem_waddr), 128'(20'h12003));
        chk("bstore_data", 128'(mem_wdata), 128'(32'h0000_00AB));
        dc_byte = 1'b0; dc_addr = 20'h12010; dc_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("store_we_pulse", 128'({mem_we, dc_gnt}), 128'(0));
        @(negedge clk);
        chk("wstore_strobes", 128'({dc_gnt, dc_ready, mem_we, mem_byte}), 128'(4'b1110));
        chk("wstore_addr_data", 128'({mem_waddr, mem_wdata}), 128'({20'h12010, 32'hDEAD_BEEF}));
        dc_req = 1'b0; dc_we = 1'b0;
        @(negedge clk);
        // timeout on a lost reply
        ic_req = 1'b1; ic_addr = 20'h08030;
        wait_gnt(gi, gd);
        ic_req = 1'b0;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (err) begin
                n = k;
                break;
            end
        end
        chk("timeout_cycles", 128'(n), 128'(64));
        chk("timeout_ready", 128'({ic_ready, dc_ready}), 128'(2'b10));
        chk("timeout_data_zero", ic_data, 128'(0));
        @(negedge clk);
        chk("err_pulse", 128'(err), 128'(0));
        dc_req = 1'b1; dc_addr = 20'h12050;
        wait_gnt(gi, gd);
        chk("after_timeout_gnt", 128'({gi, gd}), 128'(2'b01));
        dc_req = 1'b0;
        respond(20'h12050, L1);
        chk("after_timeout_data", 128'({dc_ready, err}), 128'(2'b10));
        chk("after_timeout_line", dc_data, L1);
        // reset during a read
        dc_req = 1'b1; dc_addr = 20'h12080;
        wait_gnt(gi, gd);
        dc_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rdy = 1'b1; mem_addr = 20'h12080; mem_data = L3;
        @(negedge clk);
        mem_rdy = 1'b0;
        chk("rst_mid_no_ready", 128'({ic_ready, dc_ready, err, mem_read}), 128'(0));
        chk("rst_mid_data", dc_data, 128'(0));
        ic_req = 1'b1; ic_addr = 20'h08040;
        wait_gnt(gi, gd);
        chk("post_rst_gnt", 128'({gi, gd}), 128'(2'b10));
        ic_req = 1'b0;
        respond(20'h08040, L2);
        chk("post_rst_data", ic_data, L2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
